// File: rtl/uart_tx.sv
// UART transmitter: pops one word per frame from an upstream FIFO and
// shifts it out as start, data (LSB first), optional parity and stop bits.
module uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int WORD_LEN     = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                fifo_empty,
  input  logic [WORD_LEN-1:0] fifo_data,
  output logic                fifo_re,
  output logic                tx,
  output logic                busy,
  output logic                done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(WORD_LEN) + 1;

  localparam logic [CW-1:0] CLAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BLAST = BW'(WORD_LEN - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, LATCH, START, DATA, PARITY, STOP
  } state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [BW-1:0]       bidx;
  logic [WORD_LEN-1:0] word;
  logic [WORD_LEN-1:0] nxt_word;
  logic                par;
  logic                bit_end;

  // word is never shifted so it stays intact for parity
  assign nxt_word = word >> (bidx + BW'(1));
  assign par      = (^word) ^ (PARITY_ODD != 0);
  assign bit_end  = (cnt == CLAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tx      <= 1'b1;
      fifo_re <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      cnt     <= '0;
      bidx    <= '0;
      word    <= '0;
    end else begin
      fifo_re <= 1'b0;
      done    <= 1'b0;
      unique case (state)
        IDLE: begin
          tx <= 1'b1;
          if (enable && !fifo_empty) begin
            state   <= FETCH;
            fifo_re <= 1'b1;
            busy    <= 1'b1;
          end
        end
        FETCH: state <= LATCH;
        LATCH: begin
          word  <= fifo_data;
          state <= START;
          tx    <= 1'b0;
          cnt   <= '0;
        end
        START: begin
          if (bit_end) begin
            cnt   <= '0;
            bidx  <= '0;
            tx    <= word[0];
            state <= DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (bidx == BLAST) begin
              bidx <= '0;
              if (PARITY_EN != 0) begin
                tx    <= par;
                state <= PARITY;
              end else begin
                tx    <= 1'b1;
                state <= STOP;
              end
            end else begin
              bidx <= bidx + BW'(1);
              tx   <= nxt_word[0];
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        PARITY: begin
          if (bit_end) begin
            cnt   <= '0;
            tx    <= 1'b1;
            state <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
